// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester round-robin arbiter driving the MEMCTRL host port.
// One single-beat access per IDLE -> CMD -> DATA pass; the bus is parked while BIST_EN is high.
module mem_arbiter #(
  parameter int AW = 16,
  parameter int DW = 8
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          BIST_EN,
  input  logic          REQA,
  input  logic          REQB,
  input  logic          WEA,
  input  logic          WEB_B,
  input  logic [AW-1:0] ADDRA,
  input  logic [AW-1:0] ADDRB,
  input  logic [DW-1:0] WDATAA,
  input  logic [DW-1:0] WDATAB,
  output logic          ACKA,
  output logic          ACKB,
  output logic [DW-1:0] RDATAA,
  output logic [DW-1:0] RDATAB,
  output logic [AW-1:0] MEM_ADDR,
  output logic          MEM_CE,
  output logic          MEM_CSB,
  output logic          MEM_WEB,
  output logic          MEM_OEB,
  output logic [DW-1:0] MEM_IDATA,
  input  logic [DW-1:0] MEM_ODATA,
  output logic          ARB_IDLE
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          ptr_q, ptr_d;
  logic          sel_b_q, sel_b_d;
  logic          wr_q, wr_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          ce_q, ce_d;
  logic          csb_q, csb_d;
  logic          web_q, web_d;
  logic          oeb_q, oeb_d;
  logic [DW-1:0] idata_q, idata_d;
  logic          acka_q, acka_d;
  logic          ackb_q, ackb_d;
  logic [DW-1:0] rdataa_q, rdataa_d;
  logic [DW-1:0] rdatab_q, rdatab_d;
  logic          idle_q, idle_d;

  logic          req_a_s, req_b_s, pick_b_s, pick_wr_s;
  logic [AW-1:0] pick_addr_s;
  logic [DW-1:0] pick_wdata_s;

  // Requests are masked during their own ACK cycle so a slow-dropping requester is not re-granted.
  always_comb begin
    req_a_s  = REQA & ~acka_q;
    req_b_s  = REQB & ~ackb_q;
    pick_b_s = req_b_s & (~req_a_s | ptr_q);
    if (pick_b_s) begin
      pick_wr_s    = WEB_B;
      pick_addr_s  = ADDRB;
      pick_wdata_s = WDATAB;
    end else begin
      pick_wr_s    = WEA;
      pick_addr_s  = ADDRA;
      pick_wdata_s = WDATAA;
    end
  end

  // Next-state and next-output logic; bus strobes default to their parked values.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    sel_b_d  = sel_b_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    ce_d     = 1'b0;
    csb_d    = 1'b1;
    web_d    = 1'b1;
    oeb_d    = 1'b1;
    idata_d  = {DW{1'b0}};
    acka_d   = 1'b0;
    ackb_d   = 1'b0;
    rdataa_d = rdataa_q;
    rdatab_d = rdatab_q;
    case (state_q)
      ST_IDLE: begin
        if (!BIST_EN && (req_a_s || req_b_s)) begin
          state_d = ST_CMD;
          ptr_d   = ~pick_b_s;
          sel_b_d = pick_b_s;
          wr_d    = pick_wr_s;
          addr_d  = pick_addr_s;
          ce_d    = 1'b1;
          csb_d   = 1'b0;
          web_d   = ~pick_wr_s;
          oeb_d   = pick_wr_s;
          idata_d = pick_wr_s ? pick_wdata_s : {DW{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CMD: begin
        // Output enable stays asserted for a read so MEM_ODATA is driven through DATA.
        state_d = ST_DATA;
        oeb_d   = wr_q;
      end
      ST_DATA: begin
        state_d = ST_IDLE;
        if (sel_b_q) begin
          ackb_d = 1'b1;
          if (!wr_q) begin
            rdatab_d = MEM_ODATA;
          end else begin
            rdatab_d = rdatab_q;
          end
        end else begin
          acka_d = 1'b1;
          if (!wr_q) begin
            rdataa_d = MEM_ODATA;
          end else begin
            rdataa_d = rdataa_q;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    idle_d = (state_d == ST_IDLE);
  end

  // State and registered outputs; reset abandons any in-flight access without an ACK.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q  <= ST_IDLE;
      ptr_q    <= 1'b0;
      sel_b_q  <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= {AW{1'b0}};
      ce_q     <= 1'b0;
      csb_q    <= 1'b1;
      web_q    <= 1'b1;
      oeb_q    <= 1'b1;
      idata_q  <= {DW{1'b0}};
      acka_q   <= 1'b0;
      ackb_q   <= 1'b0;
      rdataa_q <= {DW{1'b0}};
      rdatab_q <= {DW{1'b0}};
      idle_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      sel_b_q  <= sel_b_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      ce_q     <= ce_d;
      csb_q    <= csb_d;
      web_q    <= web_d;
      oeb_q    <= oeb_d;
      idata_q  <= idata_d;
      acka_q   <= acka_d;
      ackb_q   <= ackb_d;
      rdataa_q <= rdataa_d;
      rdatab_q <= rdatab_d;
      idle_q   <= idle_d;
    end
  end

  assign ACKA      = acka_q;
  assign ACKB      = ackb_q;
  assign RDATAA    = rdataa_q;
  assign RDATAB    = rdatab_q;
  assign MEM_ADDR  = addr_q;
  assign MEM_CE    = ce_q;
  assign MEM_CSB   = csb_q;
  assign MEM_WEB   = web_q;
  assign MEM_OEB   = oeb_q;
  assign MEM_IDATA = idata_q;
  assign ARB_IDLE  = idle_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed accesses push expected ACKs; a monitor pops and compares.
module tb_mem_arbiter;

  logic        CLK = 1'b0;
  logic        RSTN = 1'b0;
  logic        BIST_EN = 1'b0;
  logic        REQA = 1'b0, REQB = 1'b0, WEA = 1'b0, WEB_B = 1'b0;
  logic [15:0] ADDRA = 16'h0, ADDRB = 16'h0;
  logic [7:0]  WDATAA = 8'h0, WDATAB = 8'h0;
  logic        ACKA, ACKB, MEM_CE, MEM_CSB, MEM_WEB, MEM_OEB, ARB_IDLE;
  logic [7:0]  RDATAA, RDATAB, MEM_IDATA;
  logic [7:0]  MEM_ODATA = 8'h0;
  logic [15:0] MEM_ADDR;

  mem_arbiter #(.AW(16), .DW(8)) dut (
    .CLK(CLK), .RSTN(RSTN), .BIST_EN(BIST_EN),
    .REQA(REQA), .REQB(REQB), .WEA(WEA), .WEB_B(WEB_B),
    .ADDRA(ADDRA), .ADDRB(ADDRB), .WDATAA(WDATAA), .WDATAB(WDATAB),
    .ACKA(ACKA), .ACKB(ACKB), .RDATAA(RDATAA), .RDATAB(RDATAB),
    .MEM_ADDR(MEM_ADDR), .MEM_CE(MEM_CE), .MEM_CSB(MEM_CSB), .MEM_WEB(MEM_WEB),
    .MEM_OEB(MEM_OEB), .MEM_IDATA(MEM_IDATA), .MEM_ODATA(MEM_ODATA), .ARB_IDLE(ARB_IDLE)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // SRAM model: command sampled on the edge ending CMD, read data held through DATA.
  logic [7:0] mem [0:65535];
  always @(posedge CLK) begin
    if (!MEM_CSB && MEM_CE) begin
      if (!MEM_WEB) mem[MEM_ADDR] <= MEM_IDATA;
      else if (!MEM_OEB) MEM_ODATA <= mem[MEM_ADDR];
    end
  end

  typedef struct {
    logic       side_b;
    logic       rd;
    logic [7:0] data;
    int         exp_cyc;
  } exp_t;
  exp_t sbq[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_bus(input string name, input logic [27:0] exp);
    chk(name, {4'h0, MEM_CE, MEM_CSB, MEM_WEB, MEM_OEB, MEM_ADDR, MEM_IDATA}, {4'h0, exp});
  endtask

  task automatic chk_reset(input string name);
    chk(name, {ACKA, ACKB, RDATAA, RDATAB, ARB_IDLE, MEM_CE, MEM_CSB, MEM_WEB, MEM_OEB, MEM_ADDR, MEM_IDATA},
        {1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0000, 8'h00});
  endtask

  task automatic push(input logic side_b, input logic rd, input logic [7:0] data, input int exp_cyc);
    exp_t e;
    e.side_b = side_b; e.rd = rd; e.data = data; e.exp_cyc = exp_cyc;
    sbq.push_back(e);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Monitor: pops an expectation on every ACK and checks single-cycle CSB strobes.
  logic prev_csb = 1'b1;
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (RSTN !== 1'b1) begin
        prev_csb = 1'b1;
      end else begin
        if (prev_csb == 1'b0) chk("csb_single_cycle", {31'h0, MEM_CSB}, 32'h1);
        prev_csb = MEM_CSB;
        if (ACKA || ACKB) begin
          if (sbq.size() == 0) begin
            chk("unexpected_ack", {30'h0, ACKA, ACKB}, 32'h0);
          end else begin
            e = sbq.pop_front();
            chk("ack_side", {30'h0, ACKA, ACKB}, e.side_b ? 32'h1 : 32'h2);
            chk("ack_cycle", cyc, e.exp_cyc);
            if (e.rd) chk("rdata", {24'h0, e.side_b ? RDATAB : RDATAA}, {24'h0, e.data});
          end
        end
      end
    end
  end

  initial begin
    int c;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk_reset("reset_values");
    @(posedge CLK); #1;
    RSTN = 1'b1;

    // A writes 0010/A5
    @(posedge CLK); #1;
    REQA = 1'b1; WEA = 1'b1; ADDRA = 16'h0010; WDATAA = 8'hA5;
    c = cyc;
    push(1'b0, 1'b0, 8'h00, c + 3);
    @(negedge CLK); chk_bus("wr_grant_cycle_idle", {1'b0, 1'b1, 1'b1, 1'b1, 16'h0000, 8'h00});
    @(negedge CLK); chk_bus("wr_cmd", {1'b1, 1'b0, 1'b0, 1'b1, 16'h0010, 8'hA5});
    chk("wr_cmd_not_idle", {31'h0, ARB_IDLE}, 32'h0);
    @(negedge CLK); chk_bus("wr_data", {1'b0, 1'b1, 1'b1, 1'b1, 16'h0010, 8'h00});
    wait_cyc(c + 3);
    REQA = 1'b0;

    // B reads 0010
    @(posedge CLK); #1;
    REQB = 1'b1; WEB_B = 1'b0; ADDRB = 16'h0010;
    c = cyc;
    push(1'b1, 1'b1, 8'hA5, c + 3);
    @(negedge CLK);
    @(negedge CLK); chk_bus("rd_cmd", {1'b1, 1'b0, 1'b1, 1'b0, 16'h0010, 8'h00});
    @(negedge CLK); chk_bus("rd_data", {1'b0, 1'b1, 1'b1, 1'b0, 16'h0010, 8'h00});
    wait_cyc(c + 3);
    REQB = 1'b0;
    chk("ack_cycle_idle", {31'h0, ARB_IDLE}, 32'h1);

    // Both held high from reset: A,B,A,B every 3 cycles
    @(posedge CLK); #1;
    RSTN = 1'b0;
    REQA = 1'b1; WEA = 1'b1; ADDRA = 16'h0020; WDATAA = 8'h11;
    REQB = 1'b1; WEB_B = 1'b1; ADDRB = 16'h0021; WDATAB = 8'h22;
    @(posedge CLK); #1;
    RSTN = 1'b1;
    c = cyc;
    push(1'b0, 1'b0, 8'h00, c + 3);
    push(1'b1, 1'b0, 8'h00, c + 6);
    push(1'b0, 1'b0, 8'h00, c + 9);
    push(1'b1, 1'b0, 8'h00, c + 12);
    wait_cyc(c + 12);
    REQA = 1'b0; REQB = 1'b0;

    // BIST_EN raised during A's CMD with B pending
    @(posedge CLK); #1;
    REQA = 1'b1; WEA = 1'b1; ADDRA = 16'h0030; WDATAA = 8'h5A;
    c = cyc;
    push(1'b0, 1'b0, 8'h00, c + 3);
    @(posedge CLK); #1;
    BIST_EN = 1'b1;
    REQB = 1'b1; WEB_B = 1'b0; ADDRB = 16'h0030;
    for (int k = 2; k <= 5; k++) begin
      @(posedge CLK); #1;
      if (k == 3) REQA = 1'b0;
      @(negedge CLK);
      chk("bist_bus_parked", {31'h0, MEM_CSB}, 32'h1);
    end
    @(posedge CLK); #1;
    BIST_EN = 1'b0;
    push(1'b1, 1'b1, 8'h5A, c + 9);
    @(negedge CLK);
    chk("bist_idle", {31'h0, ARB_IDLE}, 32'h1);
    wait_cyc(c + 9);
    REQB = 1'b0;

    // Reset during CMD of an A write; afterwards A wins a simultaneous request
    @(posedge CLK); #1;
    REQA = 1'b1; WEA = 1'b1; ADDRA = 16'h0040; WDATAA = 8'h77;
    @(negedge CLK);
    @(negedge CLK);
    chk("pre_reset_cmd", {31'h0, MEM_CSB}, 32'h0);
    #2;
    RSTN = 1'b0;
    #1;
    chk_reset("reset_mid_access");
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    REQB = 1'b1; WEB_B = 1'b0; ADDRB = 16'h0040;
    RSTN = 1'b1;
    c = cyc;
    push(1'b0, 1'b0, 8'h00, c + 3);
    push(1'b1, 1'b1, 8'h77, c + 6);
    wait_cyc(c + 3);
    REQA = 1'b0;
    wait_cyc(c + 6);
    REQB = 1'b0;

    // A holds REQA through its ACK cycle: re-granted one cycle later
    @(posedge CLK); #1;
    REQA = 1'b1; WEA = 1'b0; ADDRA = 16'h0040;
    c = cyc;
    push(1'b0, 1'b1, 8'h77, c + 3);
    push(1'b0, 1'b1, 8'h77, c + 7);
    wait_cyc(c + 3);
    @(negedge CLK); chk("hold_ack_cycle_idle", {31'h0, ARB_IDLE}, 32'h1);
    @(negedge CLK); chk("no_regrant_in_ack", {31'h0, MEM_CSB}, 32'h1);
    @(negedge CLK); chk("regrant_cmd", {31'h0, MEM_CSB}, 32'h0);
    wait_cyc(c + 7);
    REQA = 1'b0;

    repeat (5) @(posedge CLK);
    #1;
    chk("scoreboard_drained", sbq.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
